// File: rtl/rob_multi_retire.sv
// In-order retirement buffer: one dispatch per cycle, NUM_CP out-of-order completions,
// up to RET_W in-order retirements, with mispredict redirect and external flush.
module rob_multi_retire #(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned NUM_CP = 2,
  parameter  int unsigned RET_W  = 2,
  parameter  int unsigned AREG_W = 5,
  parameter  int unsigned PREG_W = 6,
  localparam int unsigned TAG_W  = $clog2(DEPTH)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Flush,
  input  logic                     Disp_Valid,
  output logic                     Disp_Ready,
  input  logic [AREG_W-1:0]        Disp_Rdst,
  input  logic [PREG_W-1:0]        Disp_Phydst,
  input  logic [31:0]              Disp_PC,
  output logic [TAG_W-1:0]         Disp_Tag,
  input  logic [NUM_CP-1:0]        Cp_Valid,
  input  logic [NUM_CP*TAG_W-1:0]  Cp_Tag,
  input  logic [NUM_CP-1:0]        Cp_Mispred,
  input  logic [NUM_CP*32-1:0]     Cp_Target,
  input  logic                     Ret_En,
  output logic [RET_W-1:0]         Ret_Valid,
  output logic [RET_W*AREG_W-1:0]  Ret_Rdst,
  output logic [RET_W*PREG_W-1:0]  Ret_Phydst,
  output logic [RET_W*32-1:0]      Ret_PC,
  output logic                     Redirect_Valid,
  output logic [31:0]              Redirect_PC,
  output logic [TAG_W:0]           Count
);

  localparam int unsigned PTR_W = TAG_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, mispred_q, mispred_d;

  // Payload storage, intentionally not reset
  logic [AREG_W-1:0] rdst_q   [DEPTH];
  logic [PREG_W-1:0] phydst_q [DEPTH];
  logic [31:0]       pc_q     [DEPTH];
  logic [31:0]       target_q [DEPTH];

  logic [PTR_W-1:0] count_c;
  logic             full_c;
  logic             disp_fire_c;
  logic [TAG_W-1:0] tail_idx_c;
  logic [TAG_W-1:0] lane_idx_c [RET_W];
  logic [PTR_W-1:0] ret_cnt_c;
  logic             lane_ok_c;
  logic             chain_ok_c;
  logic             prev_mp_c;
  logic [TAG_W-1:0] cp_tag_c [NUM_CP];
  logic [NUM_CP-1:0] cp_we_c;

  assign count_c     = tail_q - head_q;
  assign full_c      = (tail_q[TAG_W-1:0] == head_q[TAG_W-1:0]) && (tail_q[TAG_W] != head_q[TAG_W]);
  assign tail_idx_c  = tail_q[TAG_W-1:0];
  assign Disp_Tag    = tail_idx_c;
  assign Count       = count_c;
  assign Disp_Ready  = !full_c && !Flush && !Redirect_Valid;
  assign disp_fire_c = Disp_Valid && Disp_Ready;

  // Retire lanes: contiguous run of done entries from head, stopping after a mispredict
  always_comb begin
    Ret_Valid      = '0;
    Ret_Rdst       = '0;
    Ret_Phydst     = '0;
    Ret_PC         = '0;
    Redirect_Valid = 1'b0;
    Redirect_PC    = '0;
    ret_cnt_c      = '0;
    lane_ok_c      = 1'b0;
    chain_ok_c     = 1'b1;
    prev_mp_c      = 1'b0;
    for (int i = 0; i < int'(RET_W); i++) begin
      lane_idx_c[i] = head_q[TAG_W-1:0] + TAG_W'(i);
      lane_ok_c = Ret_En && !Flush && (PTR_W'(i) < count_c) && done_q[lane_idx_c[i]]
                  && chain_ok_c && !prev_mp_c;
      Ret_Valid[i]                      = lane_ok_c;
      Ret_Rdst[i*AREG_W +: AREG_W]      = rdst_q[lane_idx_c[i]];
      Ret_Phydst[i*PREG_W +: PREG_W]    = phydst_q[lane_idx_c[i]];
      Ret_PC[i*32 +: 32]                = pc_q[lane_idx_c[i]];
      if (lane_ok_c) begin
        ret_cnt_c = ret_cnt_c + PTR_W'(1);
        if (mispred_q[lane_idx_c[i]]) begin
          Redirect_Valid = 1'b1;
          Redirect_PC    = target_q[lane_idx_c[i]];
        end
      end
      chain_ok_c = lane_ok_c;
      prev_mp_c  = mispred_q[lane_idx_c[i]];
    end
  end

  // Completion write enables; writes to unallocated entries are dropped
  always_comb begin
    cp_we_c = '0;
    for (int p = 0; p < int'(NUM_CP); p++) begin
      cp_tag_c[p] = Cp_Tag[p*TAG_W +: TAG_W];
      cp_we_c[p]  = Cp_Valid[p] && valid_q[cp_tag_c[p]] && !Flush && !Redirect_Valid;
    end
  end

  // Next-state: completion, then retire clear, then dispatch allocate
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    valid_d   = valid_q;
    done_d    = done_q;
    mispred_d = mispred_q;
    if (Flush || Redirect_Valid) begin
      head_d    = '0;
      tail_d    = '0;
      valid_d   = '0;
      done_d    = '0;
      mispred_d = '0;
    end else begin
      // Descending order so the lowest-numbered port wins on a tag collision
      for (int p = int'(NUM_CP) - 1; p >= 0; p--) begin
        if (cp_we_c[p]) begin
          done_d[cp_tag_c[p]]    = 1'b1;
          mispred_d[cp_tag_c[p]] = Cp_Mispred[p];
        end
      end
      for (int i = 0; i < int'(RET_W); i++) begin
        if (Ret_Valid[i]) begin
          valid_d[lane_idx_c[i]]   = 1'b0;
          done_d[lane_idx_c[i]]    = 1'b0;
          mispred_d[lane_idx_c[i]] = 1'b0;
        end
      end
      head_d = head_q + ret_cnt_c;
      if (disp_fire_c) begin
        valid_d[tail_idx_c]   = 1'b1;
        done_d[tail_idx_c]    = 1'b0;
        mispred_d[tail_idx_c] = 1'b0;
        tail_d                = tail_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      mispred_q <= mispred_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (disp_fire_c) begin
      rdst_q[tail_idx_c]   <= Disp_Rdst;
      phydst_q[tail_idx_c] <= Disp_Phydst;
      pc_q[tail_idx_c]     <= Disp_PC;
    end
    for (int p = int'(NUM_CP) - 1; p >= 0; p--) begin
      if (cp_we_c[p]) target_q[cp_tag_c[p]] <= Cp_Target[p*32 +: 32];
    end
  end

endmodule

// File: tb/tb_rob_multi_retire.sv
// Directed self-checking bench for rob_multi_retire with the default parameters.
module tb_rob_multi_retire;

  localparam int unsigned TAG_W = 4;

  logic        Clk = 1'b0;
  logic        Rst_n, Flush, Disp_Valid, Disp_Ready, Ret_En;
  logic [4:0]  Disp_Rdst;
  logic [5:0]  Disp_Phydst;
  logic [31:0] Disp_PC;
  logic [3:0]  Disp_Tag;
  logic [1:0]  Cp_Valid, Cp_Mispred;
  logic [7:0]  Cp_Tag;
  logic [63:0] Cp_Target;
  logic [1:0]  Ret_Valid;
  logic [9:0]  Ret_Rdst;
  logic [11:0] Ret_Phydst;
  logic [63:0] Ret_PC;
  logic        Redirect_Valid;
  logic [31:0] Redirect_PC;
  logic [4:0]  Count;

  int checks = 0;
  int errors = 0;

  rob_multi_retire dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .Disp_Valid(Disp_Valid), .Disp_Ready(Disp_Ready), .Disp_Rdst(Disp_Rdst),
    .Disp_Phydst(Disp_Phydst), .Disp_PC(Disp_PC), .Disp_Tag(Disp_Tag),
    .Cp_Valid(Cp_Valid), .Cp_Tag(Cp_Tag), .Cp_Mispred(Cp_Mispred), .Cp_Target(Cp_Target),
    .Ret_En(Ret_En), .Ret_Valid(Ret_Valid), .Ret_Rdst(Ret_Rdst), .Ret_Phydst(Ret_Phydst),
    .Ret_PC(Ret_PC), .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_inputs();
    Flush = 0; Disp_Valid = 0; Disp_Rdst = '0; Disp_Phydst = '0; Disp_PC = '0;
    Cp_Valid = '0; Cp_Tag = '0; Cp_Mispred = '0; Cp_Target = '0; Ret_En = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    Rst_n = 0;
    step();
    step();
    Rst_n = 1;
  endtask

  task automatic disp(input logic [31:0] pc);
    Disp_Valid = 1; Disp_PC = pc; Disp_Rdst = pc[6:2]; Disp_Phydst = pc[7:2];
    step();
    Disp_Valid = 0;
  endtask

  task automatic cp(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1,
                    input logic [1:0] mp, input logic [31:0] g0, input logic [31:0] g1);
    Cp_Valid = v; Cp_Tag = {t1, t0}; Cp_Mispred = mp; Cp_Target = {g1, g0};
    step();
    Cp_Valid = '0; Cp_Mispred = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (Ret_Valid !== 2'b00) begin errors++; $display("FAIL rst_ret_valid got %b exp 00", Ret_Valid); end
    checks++; if (Redirect_Valid !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b exp 0", Redirect_Valid); end
    checks++; if (Redirect_PC !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc got %h exp 0", Redirect_PC); end
    checks++; if (Disp_Tag !== 4'd0) begin errors++; $display("FAIL rst_disp_tag got %0d exp 0", Disp_Tag); end
    checks++; if (Disp_Ready !== 1'b1) begin errors++; $display("FAIL rst_disp_ready got %b exp 1", Disp_Ready); end
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", Count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      Disp_Valid = 1; Disp_PC = 32'h100 + 32'(i * 4);
      #1;
      checks++; if (Disp_Tag !== 4'(i)) begin errors++; $display("FAIL fill_tag got %0d exp %0d", Disp_Tag, i); end
      checks++; if (Disp_Ready !== 1'b1) begin errors++; $display("FAIL fill_ready got %b exp 1 at %0d", Disp_Ready, i); end
      step();
    end
    checks++; if (Count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", Count); end
    checks++; if (Disp_Ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", Disp_Ready); end
    step();
    Disp_Valid = 0;
    checks++; if (Count !== 5'd16) begin errors++; $display("FAIL over_count got %0d exp 16", Count); end
    checks++; if (Disp_Tag !== 4'd0) begin errors++; $display("FAIL over_tag got %0d exp 0", Disp_Tag); end
  endtask

  task automatic test_ooo();
    do_reset();
    for (int i = 0; i < 4; i++) disp(32'h200 + 32'(i * 4));
    Ret_En = 1;
    cp(2'b01, 4'd3, 4'd0, 2'b00, 32'h0, 32'h0);
    checks++; if (Ret_Valid !== 2'b00) begin errors++; $display("FAIL ooo_blk3 got %b exp 00", Ret_Valid); end
    cp(2'b01, 4'd1, 4'd0, 2'b00, 32'h0, 32'h0);
    cp(2'b01, 4'd2, 4'd0, 2'b00, 32'h0, 32'h0);
    checks++; if (Ret_Valid !== 2'b00) begin errors++; $display("FAIL ooo_blk2 got %b exp 00", Ret_Valid); end
    cp(2'b01, 4'd0, 4'd0, 2'b00, 32'h0, 32'h0);
    checks++; if (Ret_Valid !== 2'b11) begin errors++; $display("FAIL ooo_ret01 got %b exp 11", Ret_Valid); end
    checks++; if (Ret_PC !== {32'h204, 32'h200}) begin errors++; $display("FAIL ooo_pc01 got %h exp 0000020400000200", Ret_PC); end
    checks++; if (Count !== 5'd4) begin errors++; $display("FAIL ooo_cnt4 got %0d exp 4", Count); end
    step();
    checks++; if (Ret_Valid !== 2'b11) begin errors++; $display("FAIL ooo_ret23 got %b exp 11", Ret_Valid); end
    checks++; if (Ret_PC !== {32'h20C, 32'h208}) begin errors++; $display("FAIL ooo_pc23 got %h exp 0000020c00000208", Ret_PC); end
    checks++; if (Count !== 5'd2) begin errors++; $display("FAIL ooo_cnt2 got %0d exp 2", Count); end
    step();
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL ooo_cnt0 got %0d exp 0", Count); end
    checks++; if (Ret_Valid !== 2'b00) begin errors++; $display("FAIL ooo_empty got %b exp 00", Ret_Valid); end
  endtask

  task automatic test_mispred();
    do_reset();
    for (int i = 0; i < 6; i++) disp(32'h300 + 32'(i * 4));
    cp(2'b01, 4'd0, 4'd0, 2'b00, 32'h0, 32'h0);
    cp(2'b01, 4'd1, 4'd0, 2'b01, 32'h0040_0100, 32'h0);
    cp(2'b11, 4'd2, 4'd3, 2'b00, 32'h0, 32'h0);
    cp(2'b11, 4'd4, 4'd5, 2'b00, 32'h0, 32'h0);
    Ret_En = 1; Disp_Valid = 1; Disp_PC = 32'hFFFF_0000;
    #1;
    checks++; if (Ret_Valid !== 2'b11) begin errors++; $display("FAIL mp_ret got %b exp 11", Ret_Valid); end
    checks++; if (Redirect_Valid !== 1'b1) begin errors++; $display("FAIL mp_redirect got %b exp 1", Redirect_Valid); end
    checks++; if (Redirect_PC !== 32'h0040_0100) begin errors++; $display("FAIL mp_redirect_pc got %h exp 00400100", Redirect_PC); end
    checks++; if (Disp_Ready !== 1'b0) begin errors++; $display("FAIL mp_disp_ready got %b exp 0", Disp_Ready); end
    step();
    Disp_Valid = 0;
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL mp_count got %0d exp 0", Count); end
    checks++; if (Disp_Tag !== 4'd0) begin errors++; $display("FAIL mp_disp_tag got %0d exp 0", Disp_Tag); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (Ret_Valid !== 2'b00) begin errors++; $display("FAIL mp_young_ret got %b exp 00 cyc %0d", Ret_Valid, k); end
      step();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    Ret_En = 1;
    for (int i = 0; i < 14; i++) begin
      disp(32'h500 + 32'(i * 4));
      cp(2'b01, 4'(i), 4'd0, 2'b00, 32'h0, 32'h0);
      step();
    end
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL wrap_pre_count got %0d exp 0", Count); end
    checks++; if (Disp_Tag !== 4'd14) begin errors++; $display("FAIL wrap_pre_tag got %0d exp 14", Disp_Tag); end
    Ret_En = 0;
    for (int i = 0; i < 4; i++) disp(32'h1000 + 32'(i * 4));
    cp(2'b11, 4'd14, 4'd15, 2'b00, 32'h0, 32'h0);
    cp(2'b11, 4'd0, 4'd1, 2'b00, 32'h0, 32'h0);
    Ret_En = 1;
    #1;
    checks++; if (Ret_Valid !== 2'b11) begin errors++; $display("FAIL wrap_ret_a got %b exp 11", Ret_Valid); end
    checks++; if (Ret_PC !== {32'h1004, 32'h1000}) begin errors++; $display("FAIL wrap_pc_a got %h exp 0000100400001000", Ret_PC); end
    step();
    checks++; if (Ret_Valid !== 2'b11) begin errors++; $display("FAIL wrap_ret_b got %b exp 11", Ret_Valid); end
    checks++; if (Ret_PC !== {32'h100C, 32'h1008}) begin errors++; $display("FAIL wrap_pc_b got %h exp 0000100c00001008", Ret_PC); end
    checks++; if (Ret_Rdst !== {5'd3, 5'd2}) begin errors++; $display("FAIL wrap_rdst_b got %h exp 062", Ret_Rdst); end
    checks++; if (Count !== 5'd2) begin errors++; $display("FAIL wrap_count got %0d exp 2", Count); end
    step();
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL wrap_end_count got %0d exp 0", Count); end
  endtask

  task automatic test_collision();
    do_reset();
    for (int i = 0; i < 6; i++) disp(32'h600 + 32'(i * 4));
    cp(2'b11, 4'd0, 4'd1, 2'b00, 32'h0, 32'h0);
    cp(2'b11, 4'd2, 4'd3, 2'b00, 32'h0, 32'h0);
    cp(2'b01, 4'd4, 4'd0, 2'b00, 32'h0, 32'h0);
    cp(2'b11, 4'd5, 4'd5, 2'b01, 32'hDEAD_BEE0, 32'h1111_1110);
    Ret_En = 1;
    #1;
    checks++; if (Redirect_Valid !== 1'b0) begin errors++; $display("FAIL col_early_redirect got %b exp 0", Redirect_Valid); end
    step();
    step();
    checks++; if (Ret_Valid !== 2'b11) begin errors++; $display("FAIL col_ret got %b exp 11", Ret_Valid); end
    checks++; if (Redirect_Valid !== 1'b1) begin errors++; $display("FAIL col_redirect got %b exp 1", Redirect_Valid); end
    checks++; if (Redirect_PC !== 32'hDEAD_BEE0) begin errors++; $display("FAIL col_redirect_pc got %h exp deadbee0", Redirect_PC); end
    step();
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL col_count got %0d exp 0", Count); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 0; i < 7; i++) disp(32'h700 + 32'(i * 4));
    cp(2'b11, 4'd0, 4'd1, 2'b00, 32'h0, 32'h0);
    checks++; if (Count !== 5'd7) begin errors++; $display("FAIL fl_pre_count got %0d exp 7", Count); end
    Flush = 1; Disp_Valid = 1; Ret_En = 1;
    Cp_Valid = 2'b11; Cp_Tag = {4'd3, 4'd2}; Cp_Mispred = 2'b01; Cp_Target = 64'h0;
    #1;
    checks++; if (Ret_Valid !== 2'b00) begin errors++; $display("FAIL fl_ret got %b exp 00", Ret_Valid); end
    checks++; if (Disp_Ready !== 1'b0) begin errors++; $display("FAIL fl_ready got %b exp 0", Disp_Ready); end
    step();
    Flush = 0; Disp_Valid = 0; Cp_Valid = '0; Cp_Mispred = '0;
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", Count); end
    checks++; if (Ret_Valid !== 2'b00) begin errors++; $display("FAIL fl_post_ret got %b exp 00", Ret_Valid); end
    checks++; if (Disp_Tag !== 4'd0) begin errors++; $display("FAIL fl_tag got %0d exp 0", Disp_Tag); end
    Ret_En = 0;
    for (int i = 0; i < 3; i++) disp(32'h800 + 32'(i * 4));
    cp(2'b01, 4'd0, 4'd0, 2'b01, 32'h1234_5678, 32'h0);
    Rst_n = 0; Flush = 1; Disp_Valid = 1; Ret_En = 1;
    step();
    Rst_n = 1; Flush = 0; Disp_Valid = 0;
    #1;
    checks++; if (Count !== 5'd0) begin errors++; $display("FAIL rf_count got %0d exp 0", Count); end
    checks++; if (Disp_Tag !== 4'd0) begin errors++; $display("FAIL rf_tag got %0d exp 0", Disp_Tag); end
    checks++; if (Disp_Ready !== 1'b1) begin errors++; $display("FAIL rf_ready got %b exp 1", Disp_Ready); end
    checks++; if (Ret_Valid !== 2'b00) begin errors++; $display("FAIL rf_ret got %b exp 00", Ret_Valid); end
    checks++; if (Redirect_Valid !== 1'b0) begin errors++; $display("FAIL rf_redirect got %b exp 0", Redirect_Valid); end
    checks++; if (Redirect_PC !== 32'h0) begin errors++; $display("FAIL rf_redirect_pc got %h exp 0", Redirect_PC); end
    Ret_En = 0;
  endtask

  initial begin
    Rst_n = 0;
    clr_inputs();
    test_reset();
    test_fill();
    test_ooo();
    test_mispred();
    test_wrap();
    test_collision();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_multi_retire.md
Name: rob_multi_retire

Overview:
- Parametrised in-order retirement buffer for the superscalar core; successor to the single-commit reorder buffer.
- Allocates one entry per cycle at dispatch and accepts out-of-order completion from NUM_CP write-back ports.
- Retires up to RET_W oldest completed entries per cycle.
- Resolves branch mispredicts at retirement: redirects fetch and flushes all younger state.

Parameters:
DEPTH, 16, number of entries; power of 2, >= 4
NUM_CP, 2, completion ports
RET_W, 2, max entries retired per cycle; 1..DEPTH
AREG_W, 5, architectural register index width
PREG_W, 6, physical register index width
TAG_W, $clog2(DEPTH), entry index width (derived, not overridable)

Ports:
Clk  in  1  clock
Rst_n  in  1  synchronous active-low reset
Flush  in  1  external flush (exception/interrupt), synchronous
Disp_Valid  in  1  dispatch request
Disp_Ready  out  1  entry available
Disp_Rdst  in  AREG_W  architectural destination
Disp_Phydst  in  PREG_W  physical destination
Disp_PC  in  32  instruction PC
Disp_Tag  out  TAG_W  index allocated to the current dispatch
Cp_Valid  in  NUM_CP  per-port completion strobe
Cp_Tag  in  NUM_CP*TAG_W  completing entry index
Cp_Mispred  in  NUM_CP  branch resolved against prediction
Cp_Target  in  NUM_CP*32  correct next PC when Cp_Mispred=1
Ret_En  in  1  retire permission (commit stage not stalled)
Ret_Valid  out  RET_W  per-lane retire strobe; lane 0 is oldest
Ret_Rdst  out  RET_W*AREG_W  per-lane architectural destination
Ret_Phydst  out  RET_W*PREG_W  per-lane physical destination
Ret_PC  out  RET_W*32  per-lane PC
Redirect_Valid  out  1  mispredicted entry retiring this cycle
Redirect_PC  out  32  target of that entry
Count  out  TAG_W+1  current occupancy

Behaviour:
- Reset (Rst_n=0 at Clk edge):
  - All entry valid/done/mispred bits are 0.
  - Head and tail pointers are 0; Count=0.
  - Entry payload RAM is not reset.
  - Post-reset outputs: Ret_Valid=0, Redirect_Valid=0, Redirect_PC=0, Disp_Tag=0, Disp_Ready=1.
- Pointers:
  - Head and tail are TAG_W+1 bits; the extra MSB is a wrap bit.
  - Empty when pointers are equal. Full when low bits are equal and wrap bits differ.
  - Count = tail - head, modulo 2^(TAG_W+1).
- Dispatch:
  - Disp_Ready = !Full & !Flush & !Redirect_Valid.
  - When Disp_Valid & Disp_Ready: write the entry at tail (valid=1, done=0), then tail+1.
  - Disp_Tag = tail[TAG_W-1:0], combinational.
  - Entries freed in the same cycle do not raise Disp_Ready: no bypass.
- Completion:
  - Each port with Cp_Valid sets done=1 and stores mispred/target at Cp_Tag on the next edge.
  - A completion to an entry with valid=0 is ignored.
  - Two ports hitting the same tag in one cycle: done is set; the lowest-numbered port's mispred/target win.
  - A completed entry is retire-eligible from the cycle after its completion strobe (1-cycle minimum latency).
- Retire (combinational from registered state):
  - Lane i covers entry head+i.
  - Ret_Valid[i] = Ret_En & i<Count & done(head+i) & Ret_Valid[i-1] & !mispred(head+i-1).
  - Retirement stops at the first not-done entry (head-of-line blocking) and stops after a mispredicted entry.
  - On the edge: head += popcount(Ret_Valid); retired entries are cleared (valid=0, done=0).
- Redirect:
  - Redirect_Valid = 1 when some lane j has Ret_Valid[j] & mispred; Redirect_PC = that entry's target.
  - The mispredicted entry itself retires.
  - On the same edge: every entry is invalidated and head=tail=0. Any same-cycle dispatch or completion is discarded.
- External flush:
  - Flush=1 clears the buffer identically to redirect. Ret_Valid and Redirect_Valid are forced to 0 that cycle.
  - Flush wins over dispatch, completion and retire.
  - Reset wins over Flush.
- Wrap-around: indices are taken modulo DEPTH; retire lanes wrap past DEPTH-1 to entry 0 without gap.
- Simultaneous dispatch and retire when not full: Count += 1 - popcount(Ret_Valid).
- Reset mid-operation clears all state; in-flight completions are dropped.

Test Plan:
- Fill/empty: reset, dispatch 16 entries with no completion -> Disp_Ready=0 at Count=16; 17th Disp_Valid is ignored (Count stays 16); Disp_Tag sequence 0..15.
- Out-of-order completion: dispatch tags 0-3, complete 3,1,2 then 0 -> no retire until tag 0 is done. Cycle after completing tag 0: Ret_Valid=2'b11 (tags 0,1); next cycle tags 2,3 retire; Count goes 4->2->0.
- Mispredict:
  - Dispatch tags 0-5; complete tag 0 normally, then tag 1 with Cp_Mispred=1, Cp_Target=32'h0040_0100, then tags 2-5.
  - Required: Ret_Valid=2'b11, Redirect_Valid=1, Redirect_PC=32'h0040_0100; next cycle Count=0 and Disp_Tag=0.
  - Entries 2-5 never retire.
- Wrap-around: cycle dispatch/complete/retire until head=14, then dispatch 4 and complete all -> lanes retire entries 14,15 then 0,1 with PCs in dispatch order.
- Dual-port collision: both ports complete tag 5 in one cycle, port0 mispred=1 target A, port1 mispred=0 -> at retire Redirect_Valid=1, Redirect_PC=A.
- Flush/reset priority: Flush together with dispatch and completions at Count=7 -> next cycle Count=0 and Ret_Valid=0. Rst_n=0 together with Flush -> reset values on all outputs.
